player_damage_checker: RTL

- Downstream neighbour of the enemy updater in the game-tick chain; started by the enemy updater's done pulse.
- Reads the shared 40x30 level grid (3-bit cells) at the player cell and its four orthogonal neighbours.
- If any of those cells holds an enemy, applies damage to player health, subject to a tick-based invulnerability cooldown.
- Drives health/dead to the HUD and game-over logic; read-only grid client.

---
 rtl/player_damage_checker_pkg.sv | 53 +++++
 rtl/player_damage_checker_damage_cooldown.sv | 48 ++++
 rtl/player_damage_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/player_damage_checker_pkg.sv
// Shared definitions for the player damage checker.
// Contents: level grid geometry, grid cell codes, FSM state encoding, neighbour
// index encoding and an in-bounds helper for the five-cell scan.
package player_damage_checker_pkg;

    localparam int unsigned GRID_W   = 40;
    localparam int unsigned GRID_H   = 30;
    localparam int unsigned GRID_X_W = 6;
    localparam int unsigned GRID_Y_W = 5;

    localparam logic [GRID_X_W-1:0] GRID_X_MAX = GRID_X_W'(GRID_W - 1);
    localparam logic [GRID_Y_W-1:0] GRID_Y_MAX = GRID_Y_W'(GRID_H - 1);

    // Grid cell codes
    localparam logic [2:0] CELL_AIR    = 3'd0;
    localparam logic [2:0] CELL_WALL   = 3'd1;
    localparam logic [2:0] CELL_PLAYER = 3'd2;
    localparam logic [2:0] CELL_ENEMY  = 3'd4;

    // Scan order of the five cells around the player
    localparam logic [2:0] IDX_CENTRE = 3'd0;
    localparam logic [2:0] IDX_UP     = 3'd1;
    localparam logic [2:0] IDX_RIGHT  = 3'd2;
    localparam logic [2:0] IDX_DOWN   = 3'd3;
    localparam logic [2:0] IDX_LEFT   = 3'd4;

    typedef enum logic [2:0] {
        StWait  = 3'd0,
        StLatch = 3'd1,
        StAddr  = 3'd2,
        StRead  = 3'd3,
        StCheck = 3'd4,
        StApply = 3'd5,
        StDone  = 3'd6
    } state_e;

    // True when the neighbour selected by idx lies inside the grid (no wrap-around).
    function automatic logic cell_in_bounds(input logic [2:0]          idx,
                                            input logic [GRID_X_W-1:0] x,
                                            input logic [GRID_Y_W-1:0] y);
        logic ok;
        ok = 1'b1;
        case (idx)
            IDX_UP:    ok = (y != '0);
            IDX_RIGHT: ok = (x != GRID_X_MAX);
            IDX_DOWN:  ok = (y != GRID_Y_MAX);
            IDX_LEFT:  ok = (x != '0);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/player_damage_checker_damage_cooldown.sv
// Hit cooldown counter for the player damage checker.
// Ports:
//   clock   - system clock
//   reset   - synchronous active-high reset (counter cleared)
//   tick    - one pulse per completed scan (APPLY state)
//   hit_req - an enemy was found during this scan
//   ready   - cooldown expired; a hit may be applied on this tick
// The counter only moves on tick, so the cooldown is measured in game ticks.
module damage_cooldown
    import player_damage_checker_pkg::*;
#(
    parameter int unsigned COOLDOWN = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic hit_req,
    output logic ready
);

    localparam int unsigned CntW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(COOLDOWN);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign ready = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            if (hit_req && ready) begin
                cnt_d = CntLoad;
            end else if (!ready) begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/player_damage_checker.sv
// Player damage checker: after each enemy update, scans the player cell and its
// four orthogonal neighbours in the level grid and removes health when an enemy
// is adjacent, subject to a tick-based invulnerability cooldown.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   start / done        - begin-check pulse (taken only when idle) / end-of-check pulse
//   player_x / player_y - player cell, captured at the start of a check
//   grid_x / grid_y     - registered grid read address
//   grid_out            - grid cell value, sampled one wait cycle after the address
//   health / dead       - current health, sticky dead flag (health == 0)
//   hit                 - pulse when damage is actually applied
module player_damage_checker
    import player_damage_checker_pkg::*;
#(
    parameter int unsigned MAX_HEALTH = 7,
    parameter int unsigned HEALTH_W   = 4,
    parameter int unsigned DAMAGE     = 1,
    parameter int unsigned COOLDOWN   = 50,
    parameter logic [2:0]  ENEMY_CODE = 3'd4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    input  logic [GRID_X_W-1:0] player_x,
    input  logic [GRID_Y_W-1:0] player_y,
    output logic [GRID_X_W-1:0] grid_x,
    output logic [GRID_Y_W-1:0] grid_y,
    input  logic [2:0]          grid_out,
    output logic [HEALTH_W-1:0] health,
    output logic                dead,
    output logic                hit
);

    localparam logic [HEALTH_W-1:0] MaxHealthW = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DamageW    = HEALTH_W'(DAMAGE);

    state_e              state_q, state_d;
    logic [GRID_X_W-1:0] px_q, px_d;
    logic [GRID_Y_W-1:0] py_q, py_d;
    logic [2:0]          idx_q, idx_d;
    logic                found_q, found_d;
    logic [GRID_X_W-1:0] grid_x_q, grid_x_d;
    logic [GRID_Y_W-1:0] grid_y_q, grid_y_d;
    logic [HEALTH_W-1:0] health_q, health_d;

    logic                in_bounds;
    logic [GRID_X_W-1:0] cell_x;
    logic [GRID_Y_W-1:0] cell_y;
    logic                tick;
    logic                ready;
    logic                apply_hit;

    assign in_bounds = cell_in_bounds(idx_q, px_q, py_q);

    // Out-of-bounds neighbours read the centre cell; their result is masked in CHECK.
    always_comb begin
        cell_x = px_q;
        cell_y = py_q;
        if (in_bounds) begin
            case (idx_q)
                IDX_UP:    cell_y = py_q - GRID_Y_W'(1);
                IDX_RIGHT: cell_x = px_q + GRID_X_W'(1);
                IDX_DOWN:  cell_y = py_q + GRID_Y_W'(1);
                IDX_LEFT:  cell_x = px_q - GRID_X_W'(1);
                default: begin
                    cell_x = px_q;
                    cell_y = py_q;
                end
            endcase
        end
    end

    assign tick      = (state_q == StApply);
    assign apply_hit = tick && found_q && ready;

    damage_cooldown #(
        .COOLDOWN (COOLDOWN)
    ) u_cooldown (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .hit_req (found_q),
        .ready   (ready)
    );

    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        idx_d    = idx_q;
        found_d  = found_q;
        grid_x_d = grid_x_q;
        grid_y_d = grid_y_q;
        unique case (state_q)
            StWait: begin
                if (start) begin
                    state_d = dead ? StDone : StLatch;
                end
            end
            StLatch: begin
                px_d    = player_x;
                py_d    = player_y;
                idx_d   = IDX_CENTRE;
                found_d = 1'b0;
                state_d = StAddr;
            end
            StAddr: begin
                grid_x_d = cell_x;
                grid_y_d = cell_y;
                state_d  = StRead;
            end
            StRead: begin
                state_d = StCheck;
            end
            StCheck: begin
                found_d = found_q | ((grid_out == ENEMY_CODE) & in_bounds);
                if (idx_q == IDX_LEFT) begin
                    state_d = StApply;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StAddr;
                end
            end
            StApply: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StWait;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    // Saturating subtract: health never wraps below zero.
    always_comb begin
        health_d = health_q;
        if (apply_hit) begin
            health_d = (health_q <= DamageW) ? '0 : (health_q - DamageW);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StWait;
            px_q     <= '0;
            py_q     <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            grid_x_q <= '0;
            grid_y_q <= '0;
            health_q <= MaxHealthW;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            grid_x_q <= grid_x_d;
            grid_y_q <= grid_y_d;
            health_q <= health_d;
        end
    end

    assign done   = (state_q == StDone);
    assign hit    = apply_hit;
    assign health = health_q;
    assign dead   = (health_q == '0);
    assign grid_x = grid_x_q;
    assign grid_y = grid_y_q;

endmodule
